pll_gearshift_lock: RTL and testbench
=====================================

Name: pll_gearshift_lock

Overview:
Second-generation all-digital bang-bang PLL: a phase-accumulator NCO plus a sign phase detector steer phase and frequency. It adds a lock-detect state machine that gear-shifts loop gain (wide acquisition, then narrow tracking), a clamped frequency range, and a lock flag for downstream demodulation/sampling logic. It sits between the sliced RX input and the symbol-timing consumers.

Parameters:
PHASE_BITS, 32, accumulator/frequency-word width (>=8).
WIN_BITS, 6, lock window length = 2^WIN_BITS clk cycles.
LOCK_WINDOWS, 4, consecutive good windows in TRACK before LOCKED (1..15).
OPT_TRACK_FREQUENCY, 1, 0 = frequency word only changes on load_freq.
INITIAL_PHASE_STEP, 0, freq_step reset value (PHASE_BITS wide).

Ports:
clk  in  1  clock.
nrst  in  1  synchronous, active-high reset.
en  in  1  loop enable.
pll_in  in  1  sliced reference input.
load_freq  in  1  load freq into freq_step.
freq  in  PHASE_BITS-1  nominal step, loaded as {0,freq}.
freq_min  in  PHASE_BITS  lower clamp for tracked freq_step.
freq_max  in  PHASE_BITS  upper clamp for tracked freq_step.
lg_acq  in  5  log2 gain divisor in ACQUIRE.
lg_trk  in  5  log2 gain divisor in TRACK/LOCKED.
lock_thresh  in  WIN_BITS+1  max error cycles per window counted as good.
unlock_thresh  in  WIN_BITS+1  error cycles per window above which LOCKED drops.
phase  out  PHASE_BITS  accumulator ctr.
error  out  2  00 none, 01 lag, 11 lead (registered).
locked  out  1  high in LOCKED.
state  out  2  0 IDLE, 1 ACQUIRE, 2 TRACK, 3 LOCKED.

Behaviour:
- Reset (nrst=1, overrides all): ctr=0, freq_step=INITIAL_PHASE_STEP, error=00, state=IDLE, locked=0, agreed=0, window/error/good counters=0.
- phase_error = (ctr[MSB] != pll_in), combinational. agreed <= 1 when pll_in && ctr[MSB]; <= 0 when !pll_in && !ctr[MSB]; else holds (updates only when en=1). lead = agreed ? (!ctr[MSB] && pll_in) : (ctr[MSB] && !pll_in).
- lg = lg_acq in IDLE/ACQUIRE, lg_trk otherwise (combinational from current state). pc = 2^(PHASE_BITS-1) >> lg; fc = 2^(PHASE_BITS-3) >> (2*lg); a shift >= PHASE_BITS gives 0.
- When en=1 and state!=IDLE, each cycle: ctr <= ctr + freq_step + (no error: 0; lead: -pc; lag: +pc), mod 2^PHASE_BITS. error <= registered code of the same cycle.
- freq_step: load_freq has top priority (unclamped, accepted in any state and even with en=0). Else if en, state!=IDLE, OPT_TRACK_FREQUENCY, phase_error: new = freq_step -/+ fc (lead/lag), computed in PHASE_BITS+1 bits; underflow or < freq_min gives freq_min; > freq_max gives freq_max.
- en=0: ctr, freq_step, error hold; state -> IDLE next cycle; counters clear; locked=0.
- IDLE -> ACQUIRE on the first cycle with en=1 (ctr advances from the following cycle).
- Window: win_cnt increments per active cycle; err_cnt saturates at 2^WIN_BITS. At win_cnt==2^WIN_BITS-1, tot = err_cnt + phase_error (this cycle). Then win_cnt and err_cnt clear, and good = (tot <= lock_thresh).
- ACQUIRE: good window -> TRACK, good_cnt=1; else stay.
- TRACK: good -> good_cnt+1; reaching LOCK_WINDOWS -> LOCKED. Bad window -> ACQUIRE, good_cnt=0.
- LOCKED: tot > unlock_thresh -> ACQUIRE. Otherwise stay.
- locked is registered: locked = (state==LOCKED).
- load_freq while en=1 and state!=IDLE -> state ACQUIRE, all lock counters cleared (same cycle as load).
- Boundary rules: freq_min > freq_max is illegal, and the result is then freq_max. Accumulator wrap is natural modulo.

Test Plan:
PHASE_BITS=16, WIN_BITS=4, LOCK_WINDOWS=2, lg_acq=2, lg_trk=6, lock_thresh=4, unlock_thresh=8, freq_min=0, freq_max=0xFFFF unless stated.
1. Assert nrst for 2 cycles -> phase=0, error=00, state=0, locked=0, freq_step=INITIAL_PHASE_STEP. Then en=1 -> state=1 next cycle.
2. load_freq with freq=1024, en=1, pll_in square wave period 64 clk -> state goes 1->2->3 within 20 windows, locked=1. Once locked, |freq_step-1024| <= fc(lg_trk).
3. After lock, hold pll_in=0 -> state=1 and locked=0 at the end of the first following window with >8 error cycles.
4. freq_max=1100, load 1024, pll_in period 32 clk -> freq_step rises and never exceeds 1100, and stays at 1100. A mirror case with freq_min=1000 and period 128 -> freq_step floors at 1000.
5. load_freq=1 in the same cycle as a lag error, freq=500 -> freq_step=500 exactly, and state=1 with counters cleared.
6. Drop en in LOCKED -> next cycle state=0, locked=0, phase frozen. Re-raise en -> state=1, phase resumes from the frozen value.

Source files
------------

// File: rtl/pll_gearshift_lock.sv
// Bang-bang all-digital PLL: phase-accumulator NCO, sign phase detector,
// lock-detect FSM that gear-shifts loop gain and clamps the tracked frequency.
module pll_gearshift_lock #(
    parameter int PHASE_BITS = 32,
    parameter int WIN_BITS = 6,
    parameter int LOCK_WINDOWS = 4,
    parameter int OPT_TRACK_FREQUENCY = 1,
    parameter logic [PHASE_BITS-1:0] INITIAL_PHASE_STEP = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  pll_in,
    input  logic                  load_freq,
    input  logic [PHASE_BITS-2:0] freq,
    input  logic [PHASE_BITS-1:0] freq_min,
    input  logic [PHASE_BITS-1:0] freq_max,
    input  logic [4:0]            lg_acq,
    input  logic [4:0]            lg_trk,
    input  logic [WIN_BITS:0]     lock_thresh,
    input  logic [WIN_BITS:0]     unlock_thresh,
    output logic [PHASE_BITS-1:0] phase,
    output logic [1:0]            error,
    output logic                  locked,
    output logic [1:0]            state
);

    localparam int PB = PHASE_BITS;
    localparam logic [WIN_BITS-1:0] WIN_LAST = '1;
    localparam logic [WIN_BITS:0] ERR_SAT = {1'b1, {WIN_BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t fsm, fsm_nx;

    logic [PB-1:0] ctr, freq_step;
    logic          agreed;
    logic [WIN_BITS-1:0] win_cnt, win_nx;
    logic [WIN_BITS:0]   err_cnt, err_nx, tot;
    logic [3:0]          good_cnt, good_nx, good_inc;

    logic          msb, phase_error, lead, lag;
    logic          active, win_end, good;
    logic [4:0]    lg;
    logic [PB-1:0] pc, fc, corr, ctr_nx, fs_clamp;
    logic [PB:0]   fs_raw, fs_lo;

    assign msb         = ctr[PB-1];
    assign phase_error = msb != pll_in;
    assign lead        = agreed ? (!msb && pll_in) : (msb && !pll_in);
    assign lag         = phase_error && !lead;
    assign active      = en && (fsm != IDLE);

    assign lg = (fsm == IDLE || fsm == ACQUIRE) ? lg_acq : lg_trk;
    assign pc = {1'b1, {(PB-1){1'b0}}} >> lg;
    assign fc = {3'b001, {(PB-3){1'b0}}} >> {lg, 1'b0};

    always_comb begin
        corr = '0;
        if (lead)
            corr = -pc;
        else if (lag)
            corr = pc;
    end

    assign ctr_nx = ctr + freq_step + corr;

    // Frequency nudge in one extra bit so underflow/overflow are visible
    always_comb begin
        fs_raw = lead ? ({1'b0, freq_step} - {1'b0, fc})
                      : ({1'b0, freq_step} + {1'b0, fc});
        fs_lo = fs_raw;
        if ((lead && fs_raw[PB]) || fs_raw < {1'b0, freq_min})
            fs_lo = {1'b0, freq_min};
        fs_clamp = fs_lo[PB-1:0];
        if (fs_lo > {1'b0, freq_max})
            fs_clamp = freq_max;
    end

    assign win_end  = win_cnt == WIN_LAST;
    assign tot      = err_cnt + {{WIN_BITS{1'b0}}, phase_error};
    assign good     = tot <= lock_thresh;
    assign good_inc = good_cnt + 4'd1;

    always_comb begin
        fsm_nx  = fsm;
        win_nx  = win_cnt;
        err_nx  = err_cnt;
        good_nx = good_cnt;
        if (!en) begin
            fsm_nx  = IDLE;
            win_nx  = '0;
            err_nx  = '0;
            good_nx = '0;
        end else if (fsm == IDLE) begin
            fsm_nx = ACQUIRE;
        end else if (load_freq) begin
            fsm_nx  = ACQUIRE;
            win_nx  = '0;
            err_nx  = '0;
            good_nx = '0;
        end else if (win_end) begin
            win_nx = '0;
            err_nx = '0;
            unique case (fsm)
                ACQUIRE: begin
                    if (good) begin
                        fsm_nx  = TRACK;
                        good_nx = 4'd1;
                    end
                end
                TRACK: begin
                    if (good) begin
                        good_nx = good_inc;
                        if (good_inc >= 4'(LOCK_WINDOWS))
                            fsm_nx = LOCKED;
                    end else begin
                        fsm_nx  = ACQUIRE;
                        good_nx = '0;
                    end
                end
                LOCKED: begin
                    if (tot > unlock_thresh) begin
                        fsm_nx  = ACQUIRE;
                        good_nx = '0;
                    end
                end
                IDLE: ;
            endcase
        end else begin
            win_nx = win_cnt + 1'b1;
            if (phase_error && err_cnt != ERR_SAT)
                err_nx = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            ctr       <= '0;
            freq_step <= INITIAL_PHASE_STEP;
            error     <= 2'b00;
            agreed    <= 1'b0;
            fsm       <= IDLE;
            locked    <= 1'b0;
            win_cnt   <= '0;
            err_cnt   <= '0;
            good_cnt  <= '0;
        end else begin
            if (en) begin
                if (pll_in && msb)
                    agreed <= 1'b1;
                else if (!pll_in && !msb)
                    agreed <= 1'b0;
            end
            if (active) begin
                ctr   <= ctr_nx;
                error <= {lead, phase_error};
            end
            if (load_freq)
                freq_step <= {1'b0, freq};
            else if (active && OPT_TRACK_FREQUENCY != 0 && phase_error)
                freq_step <= fs_clamp;
            fsm      <= fsm_nx;
            locked   <= fsm_nx == LOCKED;
            win_cnt  <= win_nx;
            err_cnt  <= err_nx;
            good_cnt <= good_nx;
        end
    end

    assign phase = ctr;
    assign state = fsm;

endmodule

// File: tb/tb_pll_gearshift_lock.sv
// Directed bench for pll_gearshift_lock: PHASE_BITS=16, WIN_BITS=4,
// LOCK_WINDOWS=2, freq_step reset value 100.
module tb_pll_gearshift_lock;

    logic        clk = 1'b0;
    logic        nrst, en, pll_in, load_freq;
    logic [14:0] freq;
    logic [15:0] freq_min, freq_max;
    logic [4:0]  lg_acq, lg_trk;
    logic [4:0]  lock_thresh, unlock_thresh;
    logic [15:0] phase;
    logic [1:0]  error;
    logic        locked;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail = 0;
    int n = 0;

    pll_gearshift_lock #(
        .PHASE_BITS(16),
        .WIN_BITS(4),
        .LOCK_WINDOWS(2),
        .OPT_TRACK_FREQUENCY(1),
        .INITIAL_PHASE_STEP(16'd100)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .en(en),
        .pll_in(pll_in),
        .load_freq(load_freq),
        .freq(freq),
        .freq_min(freq_min),
        .freq_max(freq_max),
        .lg_acq(lg_acq),
        .lg_trk(lg_trk),
        .lock_thresh(lock_thresh),
        .unlock_thresh(unlock_thresh),
        .phase(phase),
        .error(error),
        .locked(locked),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, load a nominal step with en low, then enter ACQUIRE at ctr=0
    task automatic restart(input logic [14:0] f);
        nrst = 1'b1;
        en = 1'b0;
        load_freq = 1'b0;
        pll_in = 1'b0;
        step();
        nrst = 1'b0;
        load_freq = 1'b1;
        freq = f;
        step();
        check("load_en0_freq", 32'(dut.freq_step), 32'(f));
        check("load_en0_state", 32'(state), 0);
        load_freq = 1'b0;
        en = 1'b1;
        step();
        check("enter_acq_state", 32'(state), 1);
        check("enter_acq_phase", 32'(phase), 0);
        n = 0;
    endtask

    // Reference square wave of period 64 in phase with a 1024 step NCO
    task automatic align(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pll_in = (n % 64) >= 32;
            step();
            n++;
        end
    endtask

    initial begin
        nrst = 1'b1;
        en = 1'b1;
        pll_in = 1'b1;
        load_freq = 1'b0;
        freq = '0;
        freq_min = 16'd0;
        freq_max = 16'hFFFF;
        lg_acq = 5'd2;
        lg_trk = 5'd6;
        lock_thresh = 5'd4;
        unlock_thresh = 5'd8;

        // Reset state, reset overriding en
        step();
        step();
        check("rst_phase", 32'(phase), 0);
        check("rst_error", 32'(error), 0);
        check("rst_state", 32'(state), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_freq", 32'(dut.freq_step), 100);
        nrst = 1'b0;
        pll_in = 1'b0;
        step();
        check("idle_to_acq", 32'(state), 1);
        check("idle_to_acq_phase", 32'(phase), 0);
        step();
        check("first_advance", 32'(phase), 100);
        check("first_error", 32'(error), 0);

        // Aligned input: two good windows -> TRACK then LOCKED
        restart(15'd1024);
        align(15);
        check("w1_acq", 32'(state), 1);
        check("w1_phase", 32'(phase), 15360);
        align(1);
        check("w1_track", 32'(state), 2);
        check("w1_locked", 32'(locked), 0);
        align(15);
        check("w2_track", 32'(state), 2);
        align(1);
        check("w2_locked_state", 32'(state), 3);
        check("w2_locked", 32'(locked), 1);
        check("w2_phase", 32'(phase), 32768);
        check("w2_freq", 32'(dut.freq_step), 1024);
        check("w2_error", 32'(error), 0);

        // Hold input low: every cycle leads, narrow gain, unlock at window end
        pll_in = 1'b0;
        step();
        check("trk_lead_phase", 32'(phase), 33280);
        check("trk_lead_freq", 32'(dut.freq_step), 1022);
        check("trk_lead_error", 32'(error), 3);
        for (int i = 0; i < 14; i++)
            step();
        check("unlock_pending_state", 32'(state), 3);
        check("unlock_pending_locked", 32'(locked), 1);
        step();
        check("unlock_state", 32'(state), 1);
        check("unlock_locked", 32'(locked), 0);
        check("unlock_phase", 32'(phase), 40720);
        check("unlock_freq", 32'(dut.freq_step), 992);
        step();
        check("acq_lead_phase", 32'(phase), 33520);
        check("acq_lead_freq", 32'(dut.freq_step), 480);
        step();
        check("underflow_phase", 32'(phase), 25808);
        check("underflow_freq", 32'(dut.freq_step), 0);

        // Load in the same cycle as a lag error
        pll_in = 1'b1;
        load_freq = 1'b1;
        freq = 15'd500;
        step();
        load_freq = 1'b0;
        check("load_lag_freq", 32'(dut.freq_step), 500);
        check("load_lag_state", 32'(state), 1);
        check("load_lag_win", 32'(dut.win_cnt), 0);
        check("load_lag_err", 32'(dut.err_cnt), 0);
        check("load_lag_phase", 32'(phase), 34000);
        check("load_lag_error", 32'(error), 1);

        // Upper clamp
        freq_max = 16'd1100;
        restart(15'd1024);
        pll_in = 1'b1;
        step();
        check("clamp_hi_freq", 32'(dut.freq_step), 1100);
        check("clamp_hi_phase", 32'(phase), 9216);
        check("clamp_hi_error", 32'(error), 1);
        step();
        check("clamp_hi_hold", 32'(dut.freq_step), 1100);
        check("clamp_hi_phase2", 32'(phase), 18508);

        // Lower clamp, then illegal min > max
        freq_max = 16'hFFFF;
        freq_min = 16'd1000;
        restart(15'd20000);
        pll_in = 1'b0;
        step();
        step();
        check("pre_lo_phase", 32'(phase), 40000);
        load_freq = 1'b1;
        freq = 15'd1024;
        step();
        load_freq = 1'b0;
        check("load_lead_freq", 32'(dut.freq_step), 1024);
        check("load_lead_phase", 32'(phase), 51808);
        step();
        check("clamp_lo_freq", 32'(dut.freq_step), 1000);
        check("clamp_lo_phase", 32'(phase), 44640);
        step();
        check("clamp_lo_hold", 32'(dut.freq_step), 1000);
        check("clamp_lo_phase2", 32'(phase), 37448);
        freq_min = 16'd2000;
        freq_max = 16'd1500;
        step();
        check("min_gt_max_freq", 32'(dut.freq_step), 1500);
        check("min_gt_max_phase", 32'(phase), 30256);

        // Lock again, lag in LOCKED, then drop and re-raise en
        freq_min = 16'd0;
        freq_max = 16'hFFFF;
        restart(15'd1024);
        align(32);
        check("relock_state", 32'(state), 3);
        pll_in = 1'b1;
        step();
        check("agree_phase", 32'(phase), 33792);
        pll_in = 1'b0;
        step();
        check("trk_lag_phase", 32'(phase), 35328);
        check("trk_lag_freq", 32'(dut.freq_step), 1026);
        check("trk_lag_error", 32'(error), 1);
        check("trk_lag_state", 32'(state), 3);
        en = 1'b0;
        step();
        check("en0_state", 32'(state), 0);
        check("en0_locked", 32'(locked), 0);
        check("en0_phase", 32'(phase), 35328);
        check("en0_error", 32'(error), 1);
        step();
        check("en0_phase_hold", 32'(phase), 35328);
        check("en0_freq_hold", 32'(dut.freq_step), 1026);
        en = 1'b1;
        step();
        check("reen_state", 32'(state), 1);
        check("reen_phase", 32'(phase), 35328);
        pll_in = 1'b1;
        step();
        check("resume_phase", 32'(phase), 36354);
        check("resume_state", 32'(state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
